// File: rtl/cnn_acc_pkg.sv
// ============================================================================
// cnn_acc_pkg : shared state encoding and default widths for conv accumulators
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_acc_pkg;

  localparam int PROD_WIDTH = 23;
  localparam int TAPS       = 25;
  localparam int ACC_WIDTH  = 32;
  localparam int BIAS_WIDTH = 14;
  localparam int SHIFT      = 8;
  localparam int OUT_WIDTH  = 14;
  localparam int OUT_MAX    = (1 << (OUT_WIDTH - 1)) - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cnn_conv1_acc_relu_if.sv
// ============================================================================
// cnn_conv1_acc_relu_if : tap-in / activation-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface cnn_conv1_acc_relu_if #(
  parameter int PROD_WIDTH = cnn_acc_pkg::PROD_WIDTH,
  parameter int BIAS_WIDTH = cnn_acc_pkg::BIAS_WIDTH,
  parameter int OUT_WIDTH  = cnn_acc_pkg::OUT_WIDTH
);

  logic signed [PROD_WIDTH-1:0] in_prod;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [BIAS_WIDTH-1:0] bias;
  logic        [OUT_WIDTH-1:0]  out_data;
  logic                         out_valid;
  logic                         out_ready;

  // slave is the accumulator; master is the surrounding datapath
  modport slave (
    input  in_prod, in_valid, bias, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_prod, in_valid, bias, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/cnn_acc_requant.sv
// ============================================================================
// cnn_acc_requant : round, arithmetic shift, ReLU and saturate (combinational)
// CNN_ACC_ROUND_EN selects round-half-up instead of floor truncation.
// Rev 1.0
// ============================================================================
`default_nettype none

module cnn_acc_requant #(
  parameter int ACC_WIDTH = cnn_acc_pkg::ACC_WIDTH,
  parameter int SHIFT     = cnn_acc_pkg::SHIFT,
  parameter int OUT_WIDTH = cnn_acc_pkg::OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] act
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_WIDTH + 1;

`ifdef CNN_ACC_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(1) <<< (SHIFT - 1);
`else
  localparam logic signed [EXT_W-1:0] RND = '0;
`endif

  localparam logic signed [EXT_W-1:0] OUT_MAX_EXT = EXT_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);

  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    rounded = {sum[ACC_WIDTH-1], sum} + RND;
    shifted = rounded >>> SHIFT;
    act     = '0;
    if (shifted[EXT_W-1]) begin
      act = '0;
    end else if (shifted > OUT_MAX_EXT) begin
      act = OUT_WIDTH'(OUT_MAX_EXT);
    end else begin
      act = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnn_conv1_acc_relu.sv
// ============================================================================
// cnn_conv1_acc_relu : conv1 window accumulator with bias, requant and ReLU
// Rounding mode selected by CNN_ACC_ROUND_EN (see cnn_acc_requant).
// Rev 1.0
// ============================================================================
`default_nettype none

module cnn_conv1_acc_relu #(
  parameter int PROD_WIDTH = cnn_acc_pkg::PROD_WIDTH,
  parameter int TAPS       = cnn_acc_pkg::TAPS,
  parameter int ACC_WIDTH  = cnn_acc_pkg::ACC_WIDTH,
  parameter int BIAS_WIDTH = cnn_acc_pkg::BIAS_WIDTH,
  parameter int SHIFT      = cnn_acc_pkg::SHIFT,
  parameter int OUT_WIDTH  = cnn_acc_pkg::OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  cnn_conv1_acc_relu_if.slave   bus
);

  import cnn_acc_pkg::*;

  localparam int                CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TAPS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] tap_sum;
  logic [OUT_WIDTH-1:0]    act;
  logic                    in_ready;
  logic                    take;
  logic                    last_tap;

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){bus.in_prod[PROD_WIDTH-1]}}, bus.in_prod};
  assign bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias} <<< SHIFT;

  // The first tap seeds the window with the pre-scaled bias instead of the old sum.
  assign tap_sum  = (count_q == '0) ? (bias_ext + prod_ext) : (acc_q + prod_ext);

  assign in_ready = (state_q == S_HOLD) ? bus.out_ready : 1'b1;
  assign take     = bus.in_valid & in_ready;
  assign last_tap = (count_q == LAST);

  cnn_acc_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .sum (tap_sum),
    .act (act)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if ((state_q == S_HOLD) && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end

    // A tap taken in S_HOLD is the next window's first tap (count is already 0).
    if (take) begin
      acc_d = tap_sum;
      if (last_tap) begin
        count_d     = '0;
        out_data_d  = act;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end else begin
        count_d = count_q + CNT_W'(1);
        state_d = S_ACC;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_conv1_acc_relu.sv
// ============================================================================
// tb_cnn_conv1_acc_relu : randomized bench with arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cnn_conv1_acc_relu;

  localparam int     PW    = 23;
  localparam int     BW    = 14;
  localparam int     OW    = 14;
  localparam int     TAPS  = 25;
  localparam int     SHIFT = 8;
  localparam longint OMAX  = 8191;
`ifdef CNN_ACC_ROUND_EN
  localparam longint ROUND_EXP = 1;
`else
  localparam longint ROUND_EXP = 0;
`endif

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  cnn_conv1_acc_relu_if #(.PROD_WIDTH(PW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) bus_if ();

  cnn_conv1_acc_relu #(
    .PROD_WIDTH (PW),
    .TAPS       (TAPS),
    .ACC_WIDTH  (32),
    .BIAS_WIDTH (BW),
    .SHIFT      (SHIFT),
    .OUT_WIDTH  (OW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus_if)
  );

  always #5 ap_clk = ~ap_clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_out   = 0;
  int     n_full  = 0;
  int     cyc     = 0;
  int     prev_hs = 0;
  bit     ready_req   = 1'b1;
  bit     rand_bp     = 1'b0;
  bit     chk_spacing = 1'b0;
  bit     have_prev   = 1'b0;
  longint exp_q[$];
  longint prods[TAPS];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // floor((bias*2^SHIFT + sum + rnd) / 2^SHIFT), clamped to [0, OMAX]
  function automatic longint model(input longint b);
    longint d, s, x, q;
    d = longint'(1) << SHIFT;
    s = b * d;
    for (int i = 0; i < TAPS; i++) s += prods[i];
`ifdef CNN_ACC_ROUND_EN
    x = s + d / 2;
`else
    x = s;
`endif
    q = x / d;
    if (x < 0 && (x % d) != 0) q = q - 1;
    if (q < 0) q = 0;
    if (q > OMAX) q = OMAX;
    return q;
  endfunction

  function automatic longint rand_bias();
    logic signed [BW-1:0] t;
    t = BW'($urandom);
    return longint'(t);
  endfunction

  function automatic longint rand_prod(input bit full);
    logic signed [PW-1:0] t;
    if (full) begin
      t = PW'($urandom);
      return longint'(t);
    end
    return longint'($urandom_range(0, 4000)) - 2000;
  endfunction

  task automatic fill_const(input longint v);
    for (int i = 0; i < TAPS; i++) prods[i] = v;
  endtask

  task automatic fill_rand(input bit full);
    for (int i = 0; i < TAPS; i++) prods[i] = rand_prod(full);
  endtask

  // Drive n taps; exp < 0 means take the expected value from the model.
  task automatic send_taps(input int n, input longint b, input longint mid_b, input bit mid_rand,
                           input int gaps, input bit full, input longint exp);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps > 0 && $urandom_range(0, 99) < gaps) begin
        bus_if.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
        #1;
      end
      bus_if.in_prod  = PW'(prods[i]);
      bus_if.bias     = BW'((i == 0) ? b : (mid_rand ? rand_bias() : mid_b));
      bus_if.in_valid = 1'b1;
      w = 0;
      forever begin
        @(negedge ap_clk);
        if (bus_if.in_ready) break;
        w++;
        if (w > 200) begin
          check("in_ready_timeout", 0, 1);
          bus_if.in_valid = 1'b0;
          return;
        end
      end
      @(posedge ap_clk);
      #1;
    end
    bus_if.in_valid = 1'b0;
    if (full) begin
      n_full++;
      exp_q.push_back((exp < 0) ? model(b) : exp);
      check("out_valid_latency", longint'(bus_if.out_valid), 1);
    end
  endtask

  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      cyc++;
      #1;
      bus_if.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_req;
    end
  end

  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && bus_if.out_valid && bus_if.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("out_data", longint'(bus_if.out_data), exp_q.pop_front());
        if (chk_spacing) begin
          if (have_prev) check("b2b_spacing", longint'(cyc - prev_hs), TAPS);
          have_prev = 1'b1;
          prev_hs   = cyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d outputs seen", n_out);
    $fatal(1);
  end

  initial begin
    int n_before;
    longint bb;
    int w;
    bus_if.in_valid = 1'b0;
    bus_if.in_prod  = '0;
    bus_if.bias     = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_out_valid", longint'(bus_if.out_valid), 0);
    check("rst_out_data",  longint'(bus_if.out_data), 0);
    check("rst_in_ready",  longint'(bus_if.in_ready), 1);
    @(posedge ap_clk);
    #1;

    fill_const(256);
    send_taps(TAPS, 0, 0, 1'b0, 0, 1'b1, 25);
    @(posedge ap_clk);
    #1;
    check("single_pulse", longint'(bus_if.out_valid), 0);

    fill_const(-256);
    send_taps(TAPS, 0, 0, 1'b1, 0, 1'b1, 0);
    fill_const(4194303);
    send_taps(TAPS, 8191, 0, 1'b1, 0, 1'b1, OMAX);
    fill_const(0);
    send_taps(TAPS, 100, -5, 1'b0, 0, 1'b1, 100);
    fill_const(0);
    prods[0] = 128;
    send_taps(TAPS, 0, 0, 1'b1, 0, 1'b1, ROUND_EXP);
    repeat (3) @(posedge ap_clk);
    #1;

    // Backpressure: hold the result, then release into back-to-back windows.
    ready_req = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    fill_const(256);
    send_taps(TAPS, 50, 0, 1'b1, 0, 1'b1, 75);
    fill_rand(1'b0);
    bb = rand_bias();
    fork
      send_taps(TAPS, bb, 0, 1'b1, 0, 1'b1, -1);
      begin
        repeat (5) begin
          @(negedge ap_clk);
          check("hold_valid",    longint'(bus_if.out_valid), 1);
          check("hold_data",     longint'(bus_if.out_data), 75);
          check("hold_in_ready", longint'(bus_if.in_ready), 0);
        end
        have_prev   = 1'b0;
        chk_spacing = 1'b1;
        ready_req   = 1'b1;
      end
    join
    for (int k = 0; k < 2; k++) begin
      fill_rand(k[0]);
      send_taps(TAPS, rand_bias(), 0, 1'b1, 0, 1'b1, -1);
    end
    repeat (4) @(posedge ap_clk);
    #1;
    chk_spacing = 1'b0;

    // Reset in the middle of a window discards it.
    fill_rand(1'b0);
    send_taps(12, 300, 0, 1'b1, 0, 1'b0, -1);
    n_before = n_out;
    ap_rst_n = 1'b0;
    repeat (2) begin
      @(negedge ap_clk);
      check("midrst_out_valid", longint'(bus_if.out_valid), 0);
      check("midrst_in_ready",  longint'(bus_if.in_ready), 1);
    end
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (30) @(posedge ap_clk);
    #1;
    check("midrst_no_output", longint'(n_out), longint'(n_before));
    fill_const(256);
    send_taps(TAPS, 0, 0, 1'b1, 0, 1'b1, 25);

    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      fill_rand(($urandom_range(0, 2) == 0));
      send_taps(TAPS, rand_bias(), 0, 1'b1, 20, 1'b1, -1);
    end
    rand_bp = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge ap_clk);
      w++;
    end
    #1;
    check("drain_empty",  longint'(exp_q.size()), 0);
    check("output_count", longint'(n_out), longint'(n_full));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
